// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair, with MFHI/MFLO/MTHI/MTLO access.
// Define MDU_MADD_EN to enable the MADD/MADDU accumulate operations (ops 9/10).
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] md_A,
    input  logic [31:0] md_B,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out,
    output logic [31:0] md_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

    logic [63:0]      prod_s_s, prod_u_s, res_s;
    logic             div_signed_s, a_neg_s, b_neg_s, is_arith_s;
    logic [31:0]      a_mag_s, b_mag_s, div_by_s, quot_mag_s, rem_mag_s, quot_s, rem_s;
    logic [CNT_W-1:0] load_s;

    // Products and a single magnitude divider shared by DIV and DIVU.
    // Working on magnitudes makes 0x80000000 / -1 wrap to 0x80000000 without special casing.
    always_comb begin
        prod_s_s     = {{32{md_A[31]}}, md_A} * {{32{md_B[31]}}, md_B};
        prod_u_s     = {32'd0, md_A} * {32'd0, md_B};
        div_signed_s = (MDUOp == OP_DIV);
        a_neg_s      = div_signed_s & md_A[31];
        b_neg_s      = div_signed_s & md_B[31];
        a_mag_s      = a_neg_s ? (32'd0 - md_A) : md_A;
        b_mag_s      = b_neg_s ? (32'd0 - md_B) : md_B;
        div_by_s     = (md_B == 32'd0) ? 32'd1 : b_mag_s;
        quot_mag_s   = a_mag_s / div_by_s;
        rem_mag_s    = a_mag_s % div_by_s;
        quot_s       = (a_neg_s ^ b_neg_s) ? (32'd0 - quot_mag_s) : quot_mag_s;
        rem_s        = a_neg_s ? (32'd0 - rem_mag_s) : rem_mag_s;
    end

    // Operation decode: which ops may start, their result and their latency.
    always_comb begin
        is_arith_s = 1'b0;
        res_s      = {hi_q, lo_q};
        load_s     = MULT_LOAD;
        case (MDUOp)
            OP_MULT: begin
                is_arith_s = 1'b1;
                res_s      = prod_s_s;
            end
            OP_MULTU: begin
                is_arith_s = 1'b1;
                res_s      = prod_u_s;
            end
            OP_DIV, OP_DIVU: begin
                is_arith_s = 1'b1;
                load_s     = DIV_LOAD;
                // Divide by zero recommits the current HI/LO, which cannot change while busy.
                if (md_B == 32'd0) begin
                    res_s = {hi_q, lo_q};
                end else begin
                    res_s = {rem_s, quot_s};
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                is_arith_s = 1'b1;
                res_s      = {hi_q, lo_q} + prod_s_s;
            end
            OP_MADDU: begin
                is_arith_s = 1'b1;
                res_s      = {hi_q, lo_q} + prod_u_s;
            end
`endif
            default: begin
                is_arith_s = 1'b0;
                res_s      = {hi_q, lo_q};
                load_s     = MULT_LOAD;
            end
        endcase
    end

    // Next-state logic for the IDLE/RUN sequencer and the HI/LO registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        case (state_q)
            S_IDLE: begin
                if (start && is_arith_s) begin
                    state_d  = S_RUN;
                    cnt_d    = load_s;
                    hi_tmp_d = res_s[63:32];
                    lo_tmp_d = res_s[31:0];
                end else if (!start && (MDUOp == OP_MTHI)) begin
                    hi_d = md_A;
                end else if (!start && (MDUOp == OP_MTLO)) begin
                    lo_d = md_A;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = hi_tmp_q;
                    lo_d    = lo_tmp_q;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset discards any in-flight result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_tmp_q <= 32'd0;
            lo_tmp_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign HI_out = hi_q;
    assign LO_out = lo_q;

    // MFHI/MFLO read port, no latency.
    always_comb begin
        case (MDUOp)
            OP_MFHI: md_out = hi_q;
            OP_MFLO: md_out = lo_q;
            default: md_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed scoreboard bench for mul_div_unit; expected HI/LO results are queued at start.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] md_A, md_B;
    logic [3:0]  MDUOp;
    logic        start;
    logic        busy;
    logic [31:0] HI_out, LO_out, md_out;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] sb_q[$];

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .md_A   (md_A),
        .md_B   (md_B),
        .MDUOp  (MDUOp),
        .start  (start),
        .busy   (busy),
        .HI_out (HI_out),
        .LO_out (LO_out),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    // Reference model: 64-bit arithmetic in the bench's own terms.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint      sa, sb, q, m;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = {hi, lo};
        case (op)
            4'd1: r = 64'(sa * sb);
            4'd2: r = {32'd0, a} * {32'd0, b};
            4'd3: if (b != 32'd0) begin
                q = sa / sb;
                m = sa % sb;
                r = {m[31:0], q[31:0]};
            end
            4'd4: if (b != 32'd0) r = {a % b, a / b};
            default: r = {hi, lo};
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] v);
        @(negedge clk);
        MDUOp = op; md_A = v; start = 1'b0;
        @(negedge clk);
        MDUOp = 4'd0;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int ncyc, input string tag);
        int          cyc;
        logic [63:0] e;
        @(negedge clk);
        MDUOp = op; md_A = a; md_B = b; start = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b0; MDUOp = 4'd0;
        cyc = 0;
        for (int k = 0; k < 200 && busy; k++) begin
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'(ncyc));
        e = sb_q.pop_front();
        chk({tag, "_HI"}, {32'd0, HI_out}, {32'd0, e[63:32]});
        chk({tag, "_LO"}, {32'd0, LO_out}, {32'd0, e[31:0]});
    endtask

    initial begin
        int          cyc;
        logic [63:0] e;
        reset = 1'b1; start = 1'b0; MDUOp = 4'd0; md_A = 32'd0; md_B = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_HI", {32'd0, HI_out}, 64'd0);
        chk("reset_LO", {32'd0, LO_out}, 64'd0);
        chk("reset_md_out", {32'd0, md_out}, 64'd0);
        reset = 1'b0;

        mt(4'd7, 32'h11);
        mt(4'd8, 32'h22);
        chk("mthi", {32'd0, HI_out}, 64'h11);
        chk("mtlo", {32'd0, LO_out}, 64'h22);
        @(negedge clk);
        MDUOp = 4'd5; #1;
        chk("mfhi", {32'd0, md_out}, 64'h11);
        MDUOp = 4'd6; #1;
        chk("mflo", {32'd0, md_out}, 64'h22);
        MDUOp = 4'd0; #1;
        chk("md_out_nop", {32'd0, md_out}, 64'd0);

        do_op(4'd4, 32'd7, 32'd0, {32'h11, 32'h22}, 10, "divu_by_zero");
        do_op(4'd1, 32'hFFFFFFFE, 32'd3, {32'hFFFFFFFF, 32'hFFFFFFFA}, 5, "mult_neg");
        do_op(4'd3, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 10, "div_neg");
        do_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
              model(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, HI_out, LO_out), 5, "multu_max");
        do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 10, "div_overflow");
        do_op(4'd3, 32'd7, 32'hFFFFFFFE,
              model(4'd3, 32'd7, 32'hFFFFFFFE, HI_out, LO_out), 10, "div_pos_neg");
        do_op(4'd4, 32'd100, 32'd7, model(4'd4, 32'd100, 32'd7, HI_out, LO_out), 10, "divu");

        // Restart attempt and MTLO while busy must both be ignored.
        mt(4'd7, 32'hAAAA);
        mt(4'd8, 32'hBBBB);
        @(negedge clk);
        MDUOp = 4'd1; md_A = 32'h1234; md_B = 32'h10; start = 1'b1;
        sb_q.push_back(model(4'd1, 32'h1234, 32'h10, HI_out, LO_out));
        cyc = 0;
        @(negedge clk);
        if (busy) cyc++;
        start = 1'b0; MDUOp = 4'd0;
        @(negedge clk);
        if (busy) cyc++;
        MDUOp = 4'd2; md_A = 32'd5; md_B = 32'd7; start = 1'b1;
        chk("stale_HI_while_busy", {32'd0, HI_out}, 64'hAAAA);
        @(negedge clk);
        if (busy) cyc++;
        start = 1'b0; MDUOp = 4'd8; md_A = 32'h5;
        @(negedge clk);
        if (busy) cyc++;
        MDUOp = 4'd0;
        for (int k = 0; k < 200 && busy; k++) begin
            @(negedge clk);
            if (busy) cyc++;
        end
        chk("ignore_busy_cycles", 64'(cyc), 64'd5);
        e = sb_q.pop_front();
        chk("ignore_HI", {32'd0, HI_out}, {32'd0, e[63:32]});
        chk("ignore_LO", {32'd0, LO_out}, {32'd0, e[31:0]});
        repeat (3) @(negedge clk);
        chk("ignore_no_restart", {63'd0, busy}, 64'd0);

        // Asynchronous reset in the fourth busy cycle of a DIV.
        mt(4'd7, 32'h33);
        mt(4'd8, 32'h44);
        @(negedge clk);
        MDUOp = 4'd3; md_A = 32'd100; md_B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDUOp = 4'd0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", {63'd0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrun_reset_busy", {63'd0, busy}, 64'd0);
        chk("midrun_reset_HI", {32'd0, HI_out}, 64'd0);
        chk("midrun_reset_LO", {32'd0, LO_out}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("post_reset_busy", {63'd0, busy}, 64'd0);
        chk("post_reset_HI", {32'd0, HI_out}, 64'd0);
        chk("post_reset_LO", {32'd0, LO_out}, 64'd0);

        mt(4'd7, 32'h0);
        mt(4'd8, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
        do_op(4'd10, 32'd1, 32'd1, {32'h1, 32'h0}, 5, "maddu_wrap");
`else
        @(negedge clk);
        MDUOp = 4'd10; md_A = 32'd1; md_B = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDUOp = 4'd0;
        chk("maddu_disabled_busy", {63'd0, busy}, 64'd0);
        repeat (6) @(negedge clk);
        chk("maddu_disabled_busy_late", {63'd0, busy}, 64'd0);
        chk("maddu_disabled_HI", {32'd0, HI_out}, 64'h0);
        chk("maddu_disabled_LO", {32'd0, LO_out}, 64'hFFFFFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
